// File: rtl/vm_pkg.sv
// Shared encodings for the vending-machine slice: FSM state codes and coin values in nickel units.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [2:0] NICKEL_U  = 3'd1;
  localparam logic [2:0] DIME_U    = 3'd2;
  localparam logic [2:0] QUARTER_U = 3'd5;

endpackage

// File: rtl/vm_coin_sel.sv
// Priority coin selector (Q > D > N); flags when more than one coin is presented in a cycle.
module vm_coin_sel
  import vm_pkg::*;
(
  input  logic       N,
  input  logic       D,
  input  logic       Q,
  output logic [2:0] coin_val,
  output logic       multi_coin
);

  always_comb begin
    coin_val = 3'd0;
    if (Q)      coin_val = QUARTER_U;
    else if (D) coin_val = DIME_U;
    else if (N) coin_val = NICKEL_U;
  end

  assign multi_coin = (Q & (D | N)) | (D & N);

endmodule

// File: rtl/vm_change.sv
// Parametrised Moore vending machine with change return; optional VM_CANCEL_EN adds a CANCEL
// input that refunds the collected credit. All outputs decode from registers only.
//   state   | meaning
//   IDLE    | no credit, waiting for a coin
//   COLLECT | partial credit below price
//   VEND    | dispense pulse this cycle
//   CHANGE  | paying back remainder, dimes first
module vm_change
  import vm_pkg::*;
#(
  parameter  int PRICE_UNITS = 3,
  parameter  int MAX_UNITS   = 7,
  localparam int CW          = $clog2(MAX_UNITS + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          N,
  input  logic          D,
  input  logic          Q,
`ifdef VM_CANCEL_EN
  input  logic          CANCEL,
`endif
  output logic          O,
  output logic          CHG_D,
  output logic          CHG_N,
  output logic          REJ,
  output logic [1:0]    State,
  output logic [CW-1:0] CREDIT
);

  // Sum width must hold credit plus a quarter without wrapping.
  localparam int SW = (CW + 1 > 3) ? CW + 1 : 3;

  state_t        state, state_nxt;
  logic [CW-1:0] credit, credit_nxt;
  logic          rej, rej_nxt;
  logic [2:0]    coin_val;
  logic          multi_coin;
  logic          coin_any;
  logic          cancel;
  logic          pay_dime;
  logic [SW-1:0] sum;

  vm_coin_sel u_coin_sel (
    .N          (N),
    .D          (D),
    .Q          (Q),
    .coin_val   (coin_val),
    .multi_coin (multi_coin)
  );

`ifdef VM_CANCEL_EN
  assign cancel = CANCEL;
`else
  assign cancel = 1'b0;
`endif

  assign coin_any = N | D | Q;
  assign sum      = SW'(credit) + SW'(coin_val);
  assign pay_dime = SW'(credit) >= SW'(2);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      credit <= '0;
      rej    <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      rej    <= rej_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    rej_nxt    = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel && state == COLLECT) begin
          state_nxt = CHANGE;
          rej_nxt   = coin_any;
        end else if (coin_any) begin
          rej_nxt = multi_coin;
          if (sum > SW'(MAX_UNITS)) begin
            rej_nxt = 1'b1;
          end else begin
            credit_nxt = sum[CW-1:0];
            state_nxt  = (sum >= SW'(PRICE_UNITS)) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        rej_nxt    = coin_any;
        credit_nxt = credit - CW'(PRICE_UNITS);
        state_nxt  = (credit_nxt != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_nxt    = coin_any;
        credit_nxt = credit - (pay_dime ? CW'(2) : CW'(1));
        state_nxt  = (credit_nxt != '0) ? CHANGE : IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  assign O      = (state == VEND);
  assign CHG_D  = (state == CHANGE) && pay_dime;
  assign CHG_N  = (state == CHANGE) && !pay_dime;
  assign REJ    = rej;
  assign State  = state;
  assign CREDIT = credit;

endmodule

// File: tb/tb_vm_change.sv
// Self-checking bench for vm_change: transaction-level reference model plus directed literal checks.
module tb_vm_change;

  localparam int PRICE = 3;
  localparam int MAXU  = 7;
  localparam int CW    = $clog2(MAXU + 1);

  logic          CLK = 1'b0;
  logic          RESET, N, D, Q, CANCEL;
  logic          O, CHG_D, CHG_N, REJ;
  logic [1:0]    State;
  logic [CW-1:0] CREDIT;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  vm_change #(.PRICE_UNITS(PRICE), .MAX_UNITS(MAXU)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .N      (N),
    .D      (D),
    .Q      (Q),
`ifdef VM_CANCEL_EN
    .CANCEL (CANCEL),
`endif
    .O      (O),
    .CHG_D  (CHG_D),
    .CHG_N  (CHG_N),
    .REJ    (REJ),
    .State  (State),
    .CREDIT (CREDIT)
  );

  always #5 CLK = ~CLK;

  // Model: idle/collect credit, plus a queue of the busy cycles a vend or refund must produce.
  typedef struct {
    int st;
    int cr;
    bit o;
    bit cd;
    bit cn;
  } cyc_t;

  cyc_t busy_q[$];
  int   m_cr  = 0;
  bit   m_rej = 0;

  task automatic push_change(input int r);
    int left;
    left = r;
    while (left > 0) begin
      busy_q.push_back('{3, left, 1'b0, left >= 2, left == 1});
      left -= (left >= 2) ? 2 : 1;
    end
  endtask

  task automatic model_step();
    int coins, v, nw;
    coins = int'(N) + int'(D) + int'(Q);
    m_rej = 0;
    if (RESET) begin
      busy_q.delete();
      m_cr = 0;
      return;
    end
    if (busy_q.size() > 0) begin
      m_rej = (coins > 0);
      void'(busy_q.pop_front());
      return;
    end
`ifdef VM_CANCEL_EN
    if (CANCEL && m_cr > 0) begin
      m_rej = (coins > 0);
      push_change(m_cr);
      m_cr = 0;
      return;
    end
`endif
    if (coins == 0) return;
    v = Q ? 5 : (D ? 2 : 1);
    m_rej = (coins > 1);
    nw = m_cr + v;
    if (nw > MAXU) begin
      m_rej = 1;
    end else if (nw >= PRICE) begin
      busy_q.push_back('{2, nw, 1'b1, 1'b0, 1'b0});
      push_change(nw - PRICE);
      m_cr = 0;
    end else begin
      m_cr = nw;
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (busy_q.size() > 0) begin
        chk("state", int'(State), busy_q[0].st);
        chk("credit", int'(CREDIT), busy_q[0].cr);
        chk("o", int'(O), int'(busy_q[0].o));
        chk("chg_d", int'(CHG_D), int'(busy_q[0].cd));
        chk("chg_n", int'(CHG_N), int'(busy_q[0].cn));
      end else begin
        chk("state", int'(State), (m_cr > 0) ? 1 : 0);
        chk("credit", int'(CREDIT), m_cr);
        chk("o", int'(O), 0);
        chk("chg_d", int'(CHG_D), 0);
        chk("chg_n", int'(CHG_N), 0);
      end
      chk("rej", int'(REJ), int'(m_rej));
    end
  end

  task automatic cyc(input bit n, input bit d, input bit q, input bit r, input bit c);
    N = n; D = d; Q = q; RESET = r; CANCEL = c;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    N = 0; D = 0; Q = 0; CANCEL = 0; RESET = 1;
    cyc(0, 0, 0, 1, 0);
    chk_en = 1;
    chk("rst_state", int'(State), 0);
    chk("rst_credit", int'(CREDIT), 0);
    chk("rst_rej", int'(REJ), 0);
    chk("rst_o", int'(O), 0);

    cyc(1, 0, 0, 0, 0); chk("nnn_c1", int'(CREDIT), 1); chk("nnn_st1", int'(State), 1);
    cyc(1, 0, 0, 0, 0); chk("nnn_c2", int'(CREDIT), 2);
    cyc(1, 0, 0, 0, 0); chk("nnn_c3", int'(CREDIT), 3); chk("nnn_o", int'(O), 1);
    cyc(0, 0, 0, 0, 0); chk("nnn_idle", int'(State), 0); chk("nnn_c0", int'(CREDIT), 0);
    chk("nnn_chg", int'(CHG_D) + int'(CHG_N), 0);

    cyc(0, 0, 1, 0, 0); chk("q_c5", int'(CREDIT), 5); chk("q_o", int'(O), 1);
    cyc(0, 0, 0, 0, 0); chk("q_c2", int'(CREDIT), 2); chk("q_chgd", int'(CHG_D), 1);
    cyc(0, 0, 0, 0, 0); chk("q_idle", int'(State), 0); chk("q_c0", int'(CREDIT), 0);

    cyc(0, 1, 0, 0, 0); chk("dd_c2", int'(CREDIT), 2);
    cyc(0, 1, 0, 0, 0); chk("dd_c4", int'(CREDIT), 4); chk("dd_o", int'(O), 1);
    cyc(0, 0, 0, 0, 0); chk("dd_c1", int'(CREDIT), 1); chk("dd_chgn", int'(CHG_N), 1);
    chk("dd_chgd", int'(CHG_D), 0);
    cyc(0, 0, 0, 0, 0); chk("dd_idle", int'(State), 0);

    cyc(1, 1, 0, 0, 0); chk("nd_c2", int'(CREDIT), 2); chk("nd_rej", int'(REJ), 1);
    cyc(0, 0, 1, 0, 0); chk("col_q_c7", int'(CREDIT), 7); chk("col_q_o", int'(O), 1);
    chk("col_q_rej", int'(REJ), 0);
    cyc(0, 0, 1, 0, 0); chk("vend_q_rej", int'(REJ), 1); chk("vend_q_c4", int'(CREDIT), 4);
    cyc(0, 0, 0, 0, 0); chk("chg2_c2", int'(CREDIT), 2); chk("chg2_d", int'(CHG_D), 1);
    cyc(0, 0, 0, 0, 0); chk("chg2_idle", int'(State), 0);

    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk("rs_c7", int'(CREDIT), 7);
    cyc(0, 0, 0, 0, 0); chk("rs_chgd", int'(CHG_D), 1);
    cyc(0, 0, 0, 1, 0); chk("rs_state", int'(State), 0); chk("rs_credit", int'(CREDIT), 0);
    chk("rs_outs", int'(O) + int'(CHG_D) + int'(CHG_N) + int'(REJ), 0);

`ifdef VM_CANCEL_EN
    cyc(0, 1, 0, 0, 0); chk("cx_c2", int'(CREDIT), 2);
    cyc(0, 0, 0, 0, 1); chk("cx_state", int'(State), 3); chk("cx_chgd", int'(CHG_D), 1);
    chk("cx_o", int'(O), 0);
    cyc(0, 0, 0, 0, 0); chk("cx_idle", int'(State), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1); chk("cxn_rej", int'(REJ), 1); chk("cxn_c2", int'(CREDIT), 2);
    chk("cxn_chgd", int'(CHG_D), 1);
    cyc(0, 0, 0, 0, 0); chk("cxn_idle", int'(State), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
